// File: rtl/gray_enc_pkg.sv
// Shared definitions for the Gray-encoder arbiter.
// Contents:
//   GRAY_W_DEF    - default binary/Gray word width
//   GRAY_NREQ_DEF - default number of requesters
//   bin2gray()    - reference binary-to-Gray conversion at the default width
package gray_enc_pkg;

  localparam int GRAY_W_DEF    = 10;
  localparam int GRAY_NREQ_DEF = 4;

  // The MSB passes straight through; every lower bit is the XOR of itself
  // with its upper neighbour.
  function automatic logic [GRAY_W_DEF-1:0] bin2gray(input logic [GRAY_W_DEF-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/enc_bin2gray.sv
// Shared combinational binary-to-Gray encoder.
// Ports:
//   bin  - binary input word
//   gray - Gray-coded output word
module enc_bin2gray
  import gray_enc_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEF
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_enc_arbiter.sv
// Round-robin arbiter that time-shares one binary-to-Gray encoder between
// NREQ requesters and returns the registered result tagged with the id of
// the requester that produced it.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   req_valid - per-requester request valid
//   req_bin   - requester i value in bits [i*WIDTH +: WIDTH]
//   req_ready - one-hot grant, combinational
//   rsp_valid - response register holds a result
//   rsp_ready - consumer accepts the response
//   rsp_gray  - Gray code of the accepted value
//   rsp_id    - index of the requester that produced rsp_gray
module gray_enc_arbiter
  import gray_enc_pkg::*;
#(
  parameter  int WIDTH = GRAY_W_DEF,
  parameter  int NREQ  = GRAY_NREQ_DEF,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_bin,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_gray,
  output logic [IDW-1:0]        rsp_id
);

  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_gray_q,  rsp_gray_d;
  logic [IDW-1:0]   rsp_id_q,    rsp_id_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;

  logic             slot_free;
  logic             grant;
  logic             found;
  logic [NREQ-1:0]  rot_valid;
  logic [IDW-1:0]   gnt_idx;
  logic [WIDTH-1:0] sel_bin;
  logic [WIDTH-1:0] sel_gray;
  int               start;
  int               sum;

  // A held result blocks new grants unless it is being drained this cycle.
  assign slot_free = !rsp_valid_q || rsp_ready;

  // Round-robin pick: rotate so the requester after last_grant sits at bit 0,
  // take the lowest set bit, then map the offset back to a requester index.
  always_comb begin
    start = int'(last_grant_q) + 1;
    if (start >= NREQ) start = 0;
    rot_valid = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = start + k;
      if (idx >= NREQ) idx = idx - NREQ;
      rot_valid[k] = req_valid[idx];
    end
    found = 1'b0;
    sum   = start;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        found = 1'b1;
        sum   = start + k;
      end
    end
    if (sum >= NREQ) sum = sum - NREQ;
    gnt_idx = IDW'(sum);
  end

  assign grant = found && slot_free && !rst;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = grant && (gnt_idx == IDW'(i));
    end
  end

  assign sel_bin = req_bin[int'(gnt_idx)*WIDTH +: WIDTH];

  enc_bin2gray #(
    .WIDTH(WIDTH)
  ) u_enc (
    .bin (sel_bin),
    .gray(sel_gray)
  );

  // A grant is always to a valid requester, so grant equals a transfer.
  // An accept overwrites a draining result in the same edge.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_gray_d   = rsp_gray_q;
    rsp_id_d     = rsp_id_q;
    last_grant_d = last_grant_q;
    if (grant) begin
      rsp_valid_d  = 1'b1;
      rsp_gray_d   = sel_gray;
      rsp_id_d     = gnt_idx;
      last_grant_d = gnt_idx;
    end else if (rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_gray_q   <= '0;
      rsp_id_q     <= '0;
      last_grant_q <= IDW'(NREQ - 1);
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_gray_q   <= rsp_gray_d;
      rsp_id_q     <= rsp_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_gray  = rsp_gray_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: doc/gray_enc_arbiter.md
# gray_enc_arbiter

Round-robin arbiter that shares a single binary-to-Gray encoder (`enc_bin2gray`) between `NREQ` requesters. Each requester presents a `WIDTH`-bit binary value with a valid/ready handshake. The arbiter grants one requester per cycle and encodes the granted value. It returns the Gray result, tagged with the requester id, through a registered valid/ready response port. The block sits between pointer/counter producers and the single shared Gray datapath.

## Interface
- `WIDTH`, default 10: binary/Gray word width, minimum 2.
- `NREQ`, default 4: number of requesters, minimum 2.
- `IDW`, default `$clog2(NREQ)`: id width (derived, not overridden).
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_bin`  in  NREQ*WIDTH  requester i value in bits `[i*WIDTH +: WIDTH]`.
- `req_ready`  out  NREQ  one-hot grant/accept; at most one bit high per cycle.
- `rsp_valid`  out  1  response register holds a result.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_gray`  out  WIDTH  Gray code of the accepted value.
- `rsp_id`  out  IDW  index of the requester that produced `rsp_gray`.

## Operation
- Encoding: `gray[WIDTH-1] = bin[WIDTH-1]`; `gray[i] = bin[i+1] ^ bin[i]` for i < WIDTH-1.
- Slot free: `slot_free = !rsp_valid || rsp_ready`.
- Grant: when `slot_free` and any `req_valid` is high, grant the first valid requester scanning upward from `last_grant+1`, modulo NREQ. Drive `req_ready[g]=1` combinationally. All other `req_ready` bits are 0.
- Accept: a transfer happens when `req_valid[g] && req_ready[g]`. On the next edge:
  - `rsp_gray <= gray(req_bin[g])`
  - `rsp_id <= g`
  - `rsp_valid <= 1`
  - `last_grant <= g`
- Drain with no accept: if `rsp_valid && rsp_ready` and nothing is accepted, `rsp_valid <= 0`. `rsp_gray` and `rsp_id` hold their values.
- Backpressure: while `rsp_valid && !rsp_ready`, all `req_ready` are 0. `rsp_gray`, `rsp_id` and `rsp_valid` are held stable.
- Simultaneous drain and accept: the new result replaces the old one in the same edge, so throughput is one result per cycle.
- Requester rules:
  - Once asserted, `req_valid[i]` stays high and `req_bin` slice i stays stable until accepted.
  - The arbiter does not check these rules.
- Fairness: a continuously requesting requester waits at most NREQ-1 grants.
- No requests: `last_grant` is unchanged.
- Reset:
  - `rsp_valid=0`, `rsp_gray=0`, `rsp_id=0`, `last_grant=NREQ-1`, so requester 0 has first priority.
  - `req_ready` is forced to 0 while `rst` is high.
  - Reset mid-operation discards any pending response without handshake.

## Timing
- Latency: accept in cycle N, so `rsp_valid` with the result is seen in cycle N+1.
- `req_ready` depends combinationally on `rsp_valid`, `rsp_ready`, `req_valid` and `last_grant`.
- No combinational path from `req_bin` to any output; the encoder output is registered.
- `rsp_*` are driven directly from flops.
- Sustained rate: 1 result/cycle when `rsp_ready` is held high.

## Structure
- Package `gray_enc_pkg`:
  - Function `bin2gray(logic [WIDTH-1:0])`, used by the bench model.
  - Localparam defaults `GRAY_W_DEF=10` and `GRAY_NREQ_DEF=4`.
- Sub-module: one instance of `enc_bin2gray` (the existing shared encoder) on the muxed granted value.
  - For `WIDTH≠10`, a generic-width encoder with the same port names `bin`/`gray` is used.
- Round-robin pick logic is kept inline (rotate, priority-encode, unrotate).

## Test plan
- Reset, then a single request: hold `rst` 2 cycles, then `req_valid=4'b0001`, `bin0=10'd5`, `rsp_ready=1`.
  - `req_ready=4'b0001` in the same cycle.
  - Next cycle: `rsp_valid=1`, `rsp_gray=10'd7`, `rsp_id=0`.
- Encoding corners, one per cycle on requester 2:
  - `10'h3FF -> 10'h200`
  - `10'h2AA -> 10'h3FF`
  - `10'h200 -> 10'h300`
  - `10'd0 -> 10'd0`
- Round-robin: all four requesters valid for 8 cycles with `rsp_ready=1`.
  - Grant order is 0,1,2,3,0,1,2,3.
  - `rsp_id` follows the same sequence one cycle later.
- Backpressure: `rsp_ready=0` for 3 cycles while holding a result from `bin=10'd2`.
  - `rsp_gray=10'd3` stays stable and all `req_ready=0`.
  - Releasing `rsp_ready` accepts the next requester in the same cycle.
- Reset mid-operation: assert `rst` while `rsp_valid=1` and requests are pending.
  - Next cycle: `rsp_valid=0`, `rsp_gray=0`, `rsp_id=0`.
  - First grant after reset goes to requester 0.
- Random stress: random valid/ready traffic for 10k cycles.
  - Every accepted value is returned exactly once, in order, as `bin2gray(value)` with the correct id.
  - `req_ready` is never more than one-hot.
